// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU: stage 1 registers operands, stage 2 registers result and flags.
// Optional sticky overflow flag enabled by defining ALU_PIPE_STICKY_OVF_EN.
module alu_pipe #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
`ifdef ALU_PIPE_STICKY_OVF_EN
  ,
  output logic             sticky_ovf,
  input  logic             sticky_clr
`endif
);

  typedef enum logic [2:0] {
    OpAdd  = 3'd0,
    OpSub  = 3'd1,
    OpXor  = 3'd2,
    OpSlt  = 3'd3,
    OpAnd  = 3'd4,
    OpNand = 3'd5,
    OpNor  = 3'd6,
    OpOr   = 3'd7
  } op_e;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  op_e              s1_op;
  logic             s1_advance;

  assign s1_advance = !out_valid || out_ready;
  assign in_ready   = !s1_valid || s1_advance;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OpAdd;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a  <= a;
        s1_b  <= b;
        s1_op <= op_e'(op);
      end
    end
  end

  logic             sub_sel;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             sum_ovf;
  logic [WIDTH-1:0] res_d;
  logic             cy_d;
  logic             of_d;

  // SUB and SLT share the a + ~b + 1 path; SLT reads sign XOR overflow of the difference.
  always_comb begin
    sub_sel = (s1_op == OpSub) || (s1_op == OpSlt);
    b_eff   = sub_sel ? ~s1_b : s1_b;
    sum     = {1'b0, s1_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_sel};
    sum_ovf = (s1_a[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum[WIDTH-1]) ^ sum[WIDTH];
    res_d   = '0;
    cy_d    = 1'b0;
    of_d    = 1'b0;
    unique case (s1_op)
      OpAdd, OpSub: begin
        res_d = sum[WIDTH-1:0];
        cy_d  = sum[WIDTH];
        of_d  = sum_ovf;
      end
      OpSlt:  res_d = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ sum_ovf};
      OpXor:  res_d = s1_a ^ s1_b;
      OpAnd:  res_d = s1_a & s1_b;
      OpNand: res_d = ~(s1_a & s1_b);
      OpNor:  res_d = ~(s1_a | s1_b);
      OpOr:   res_d = s1_a | s1_b;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      carryout  <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else if (s1_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result   <= res_d;
        carryout <= cy_d;
        overflow <= of_d;
        zero     <= (res_d == '0);
      end
    end
  end

`ifdef ALU_PIPE_STICKY_OVF_EN
  // A delivered overflow wins over a same-edge clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_ovf <= 1'b0;
    end else if (out_valid && out_ready && overflow) begin
      sticky_ovf <= 1'b1;
    end else if (sticky_clr) begin
      sticky_ovf <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: WIDTH=32 and WIDTH=8 instances checked against a queue-based model.
module tb_alu_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  iv, ordy, ir, ov, cy, of, zr;
  logic [63:0] a_in [2];
  logic [63:0] b_in [2];
  logic [2:0]  op_in [2];
  logic [31:0] res32;
  logic [7:0]  res8;
  logic [63:0] res [2];
  assign res[0] = {32'h0, res32};
  assign res[1] = {56'h0, res8};
`ifdef ALU_PIPE_STICKY_OVF_EN
  logic [1:0] st, clr;
`endif

  alu_pipe #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a_in[0][31:0]), .b(b_in[0][31:0]), .op(op_in[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .result(res32),
    .carryout(cy[0]), .overflow(of[0]), .zero(zr[0])
`ifdef ALU_PIPE_STICKY_OVF_EN
    , .sticky_ovf(st[0]), .sticky_clr(clr[0])
`endif
  );

  alu_pipe #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a_in[1][7:0]), .b(b_in[1][7:0]), .op(op_in[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .result(res8),
    .carryout(cy[1]), .overflow(of[1]), .zero(zr[1])
`ifdef ALU_PIPE_STICKY_OVF_EN
    , .sticky_ovf(st[1]), .sticky_clr(clr[1])
`endif
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Returns {carry, overflow, zero, result[63:0]} from signed/unsigned integer arithmetic.
  function automatic logic [66:0] model(input int w, input logic [2:0] o,
                                        input logic [63:0] x, input logic [63:0] y);
    logic [63:0] mask, r, xm, ym;
    logic c, v;
    logic signed [66:0] sx, sy, s, maxv;
    mask = (64'd1 << w) - 64'd1;
    xm = x & mask;
    ym = y & mask;
    sx = $signed({3'b000, xm});
    sy = $signed({3'b000, ym});
    if (xm[w-1]) sx = sx - $signed(67'd1 << w);
    if (ym[w-1]) sy = sy - $signed(67'd1 << w);
    maxv = $signed(67'd1 << (w - 1));
    c = 1'b0;
    v = 1'b0;
    s = '0;
    case (o)
      3'd0: begin
        s = sx + sy;
        r = (xm + ym) & mask;
        c = ({1'b0, xm} + {1'b0, ym}) >= (65'd1 << w);
        v = (s >= maxv) || (s < -maxv);
      end
      3'd1: begin
        s = sx - sy;
        r = (xm - ym) & mask;
        c = xm >= ym;
        v = (s >= maxv) || (s < -maxv);
      end
      3'd2: r = xm ^ ym;
      3'd3: r = (sx < sy) ? 64'd1 : 64'd0;
      3'd4: r = xm & ym;
      3'd5: r = ~(xm & ym) & mask;
      3'd6: r = ~(xm | ym) & mask;
      default: r = xm | ym;
    endcase
    return {c, v, r == 64'd0, r};
  endfunction

  // In-flight commands per lane, oldest at hd.
  logic [63:0] q_res [2][4];
  logic        q_cy  [2][4];
  logic        q_of  [2][4];
  logic        q_zr  [2][4];
  int          q_at  [2][4];
  int          hd [2];
  int          tl [2];
  logic [1:0]  dovf;
`ifdef ALU_PIPE_STICKY_OVF_EN
  logic [1:0]  exp_st;
`endif

  always @(negedge clk) begin
    int w, cnt, h, t;
    logic exp_ov;
    logic [66:0] m;
    dovf = 2'b00;
    for (int k = 0; k < 2; k++) begin
      w = (k == 0) ? 32 : 8;
      if (!rst_n) begin
        chk("reset out_valid", {63'h0, ov[k]}, 64'd0);
        chk("reset in_ready", {63'h0, ir[k]}, 64'd1);
        chk("reset result", res[k], 64'd0);
        chk("reset flags", {61'h0, cy[k], of[k], zr[k]}, 64'd0);
        hd[k] = 0;
        tl[k] = 0;
      end else begin
        cnt = tl[k] - hd[k];
        h = hd[k] % 4;
        exp_ov = (cnt > 0) && (cyc >= q_at[k][h]);
        chk("in_ready", {63'h0, ir[k]}, {63'h0, !(cnt == 2 && !ordy[k])});
        chk("out_valid", {63'h0, ov[k]}, {63'h0, exp_ov});
        if (ov[k] && exp_ov) begin
          chk("result", res[k], q_res[k][h]);
          chk("carryout", {63'h0, cy[k]}, {63'h0, q_cy[k][h]});
          chk("overflow", {63'h0, of[k]}, {63'h0, q_of[k][h]});
          chk("zero", {63'h0, zr[k]}, {63'h0, q_zr[k][h]});
          if (ordy[k]) begin
            dovf[k] = q_of[k][h];
            hd[k]++;
          end
        end
        if (iv[k] && ir[k]) begin
          m = model(w, op_in[k], a_in[k], b_in[k]);
          t = tl[k] % 4;
          q_res[k][t] = m[63:0];
          q_zr[k][t] = m[64];
          q_of[k][t] = m[65];
          q_cy[k][t] = m[66];
          q_at[k][t] = cyc + 2;
          tl[k]++;
        end
      end
`ifdef ALU_PIPE_STICKY_OVF_EN
      if (!rst_n) exp_st[k] = 1'b0;
      chk("sticky_ovf", {63'h0, st[k]}, {63'h0, exp_st[k]});
      if (rst_n) exp_st[k] = dovf[k] ? 1'b1 : (clr[k] ? 1'b0 : exp_st[k]);
`endif
    end
  end

  // Single command on an idle lane, checked for 2-cycle latency and literal values.
  task automatic lit(input int k, input logic [2:0] o, input logic [63:0] x, input logic [63:0] y,
                     input logic [63:0] er, input logic ec, input logic eo, input logic ez,
                     input string nm);
    @(posedge clk); #1;
    ordy[k] = 1'b1;
    iv[k] = 1'b1;
    op_in[k] = o;
    a_in[k] = x;
    b_in[k] = y;
    @(posedge clk); #1;
    iv[k] = 1'b0;
    chk({nm, " valid N+1"}, {63'h0, ov[k]}, 64'd0);
    @(posedge clk); #1;
    chk({nm, " valid N+2"}, {63'h0, ov[k]}, 64'd1);
    chk({nm, " result"}, res[k], er);
    chk({nm, " flags"}, {61'h0, cy[k], of[k], zr[k]}, {61'h0, ec, eo, ez});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc, idx, got, seen;
    logic took;
    logic [15:0] pat;
    logic [31:0] tmp;
    iv = 2'b00;
    ordy = 2'b11;
    for (int k = 0; k < 2; k++) begin
      a_in[k] = '0;
      b_in[k] = '0;
      op_in[k] = '0;
    end
`ifdef ALU_PIPE_STICKY_OVF_EN
    clr = 2'b00;
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("in_ready after reset", {63'h0, ir[0]}, 64'd1);

    lit(0, 3'd0, 64'h7FFFFFFF, 64'h1, 64'h80000000, 1'b0, 1'b1, 1'b0, "add_ovf");
    lit(0, 3'd1, 64'h802, 64'h1, 64'h801, 1'b1, 1'b0, 1'b0, "sub");
    lit(0, 3'd1, 64'h12345678, 64'h12345678, 64'h0, 1'b1, 1'b0, 1'b1, "sub_zero");
    lit(0, 3'd3, 64'hFFFFFFFF, 64'h1, 64'h1, 1'b0, 1'b0, 1'b0, "slt_neg");
    lit(0, 3'd3, 64'h1, 64'hFFFFFFFF, 64'h0, 1'b0, 1'b0, 1'b1, "slt_pos");
    lit(0, 3'd2, 64'hF0F00F0F, 64'hFF00FF00, 64'h0FF0F00F, 1'b0, 1'b0, 1'b0, "xor");
    lit(0, 3'd4, 64'hF0F00F0F, 64'hFF00FF00, 64'hF0000F00, 1'b0, 1'b0, 1'b0, "and");
    lit(0, 3'd5, 64'hF0F00F0F, 64'hFF00FF00, 64'h0FFFF0FF, 1'b0, 1'b0, 1'b0, "nand");
    lit(0, 3'd6, 64'hF0F00F0F, 64'hFF00FF00, 64'h000F00F0, 1'b0, 1'b0, 1'b0, "nor");
    lit(0, 3'd7, 64'hF0F00F0F, 64'hFF00FF00, 64'hFFF0FF0F, 1'b0, 1'b0, 1'b0, "or");
    lit(0, 3'd0, 64'hFFFFFFFF, 64'h1, 64'h0, 1'b1, 1'b0, 1'b1, "add_carry");
    lit(0, 3'd1, 64'h80000000, 64'h1, 64'h7FFFFFFF, 1'b1, 1'b1, 1'b0, "sub_ovf");
    lit(1, 3'd5, 64'hF0, 64'h3C, 64'hCF, 1'b0, 1'b0, 1'b0, "nand8");

    // Back-to-back stream: one acceptance per cycle.
    acc = 0;
    @(posedge clk); #1;
    iv[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      op_in[0] = 3'(i);
      a_in[0] = 64'(i * 32'h11111111);
      b_in[0] = 64'(32'h80000000 - 32'(i));
      @(negedge clk);
      if (ir[0]) acc++;
      @(posedge clk); #1;
    end
    iv[0] = 1'b0;
    chk("throughput", 64'(acc), 64'd8);

    // Irregular backpressure with continuous offers.
    pat = 16'b1011_0010_1110_0101;
    idx = 0;
    iv[0] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tmp = 32'h9E3779B9 * 32'(idx + 1);
      op_in[0] = 3'(idx);
      a_in[0] = {32'h0, tmp};
      b_in[0] = {32'h0, tmp ^ 32'h7FFF0001};
      ordy[0] = pat[i];
      @(negedge clk);
      took = ir[0];
      @(posedge clk); #1;
      if (took) idx++;
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    repeat (4) @(posedge clk);

    // Stall: two accepted, third held off, then ordered drain.
    #1;
    ordy[0] = 1'b0;
    iv[0] = 1'b1;
    op_in[0] = 3'd0;
    a_in[0] = 64'd1;
    b_in[0] = 64'd1;
    idx = 1;
    acc = 0;
    repeat (5) begin
      @(negedge clk);
      took = ir[0];
      @(posedge clk); #1;
      if (took) begin
        acc++;
        idx++;
        a_in[0] = 64'(idx);
        b_in[0] = 64'(idx);
      end
    end
    chk("stall accepted", 64'(acc), 64'd2);
    chk("stall in_ready", {63'h0, ir[0]}, 64'd0);
    chk("stall out_valid", {63'h0, ov[0]}, 64'd1);
    chk("stall result held", res[0], 64'h2);
    ordy[0] = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 3; c++) begin
      @(negedge clk);
      if (ov[0]) begin
        chk("stall order", res[0], 64'(2 * (got + 1)));
        got++;
      end
      took = ir[0] && iv[0];
      @(posedge clk); #1;
      if (took) iv[0] = 1'b0;
    end
    chk("stall drained", 64'(got), 64'd3);
    repeat (2) @(posedge clk);

    // Reset with both stages full.
    #1;
    ordy[0] = 1'b0;
    iv[0] = 1'b1;
    a_in[0] = 64'd5;
    b_in[0] = 64'd6;
    @(posedge clk); #1;
    a_in[0] = 64'd7;
    b_in[0] = 64'd8;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    chk("full out_valid", {63'h0, ov[0]}, 64'd1);
    chk("full in_ready", {63'h0, ir[0]}, 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset out_valid", {63'h0, ov[0]}, 64'd0);
    chk("async reset result", res[0], 64'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    ordy[0] = 1'b1;
    chk("in_ready post reset", {63'h0, ir[0]}, 64'd1);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (ov[0]) seen++;
    end
    chk("no result after reset", 64'(seen), 64'd0);

`ifdef ALU_PIPE_STICKY_OVF_EN
    lit(1, 3'd0, 64'h7F, 64'h01, 64'h80, 1'b0, 1'b1, 1'b0, "add8_ovf");
    @(posedge clk); #1;
    chk("sticky set", {63'h0, st[1]}, 64'd1);
    lit(1, 3'd4, 64'h0F, 64'h3C, 64'h0C, 1'b0, 1'b0, 1'b0, "and8");
    @(posedge clk); #1;
    chk("sticky stays", {63'h0, st[1]}, 64'd1);
    clr[1] = 1'b1;
    @(posedge clk); #1;
    clr[1] = 1'b0;
    chk("sticky cleared", {63'h0, st[1]}, 64'd0);
    lit(1, 3'd0, 64'h7F, 64'h01, 64'h80, 1'b0, 1'b1, 1'b0, "add8_ovf2");
    clr[1] = 1'b1;
    @(posedge clk); #1;
    clr[1] = 1'b0;
    chk("sticky set beats clear", {63'h0, st[1]}, 64'd1);
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
